// File: rtl/eth_bridge_pkg.sv
// Shared types for the Ethernet bridge receive path.
// Contents: write/read FSM state enums of rx_frame_buffer, drop-reason encoding, default
// minimum frame length and the width of one frame RAM entry ({last, data}).
package eth_bridge_pkg;

  localparam int unsigned MinBytesDefault = 14;
  localparam int unsigned EntryW          = 9;

  typedef enum logic [1:0] {
    WrIdle,
    WrRecv,
    WrDrop
  } wr_state_e;

  typedef enum logic [1:0] {
    RdIdle,
    RdFetch,
    RdStream
  } rd_state_e;

  typedef enum logic [1:0] {
    DropNone,
    DropOvf,
    DropErr,
    DropRunt
  } drop_reason_e;

endpackage

// File: rtl/rx_frame_buffer_if.sv
// Byte-stream bundle around rx_frame_buffer: MAC receive side in, forwarding side out.
// Modports:
//   master - the surrounding logic: drives rx_mac_* and out_ready, observes out_*
//   slave  - the frame buffer: consumes rx_mac_* and out_ready, drives out_*
interface rx_frame_buffer_if;

  logic       rx_mac_valid;
  logic [7:0] rx_mac_data;
  logic       rx_mac_last;
  logic       rx_mac_error;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  modport master (
    output rx_mac_valid, rx_mac_data, rx_mac_last, rx_mac_error, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  rx_mac_valid, rx_mac_data, rx_mac_last, rx_mac_error, out_ready,
    output out_valid, out_data, out_last
  );

endinterface

// File: rtl/rx_frame_ram.sv
// Simple dual-port frame RAM, 2^AddrW entries of {last, data}.
// Ports:
//   clk_i                          - clock
//   wr_en_i, wr_addr_i, wr_data_i  - write port
//   rd_en_i, rd_addr_i, rd_data_o  - read port, one-cycle registered latency; rd_data_o holds
//                                    its value while rd_en_i is low
// The array has no reset.
module rx_frame_ram
  import eth_bridge_pkg::*;
#(
  parameter int unsigned AddrW = 11
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AddrW-1:0]  wr_addr_i,
  input  logic [EntryW-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AddrW-1:0]  rd_addr_i,
  output logic [EntryW-1:0] rd_data_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [EntryW-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/rx_frame_buffer.sv
// Store-and-forward receive frame buffer behind the MAC. Frames are written into a circular
// RAM and released to the output only once complete and clean; errored, runt (< MIN_BYTES)
// and overflowing frames are rolled back and signalled by a one-cycle frame_drop pulse.
// Ports:
//   rx_mac_clk     - the only clock
//   reset          - synchronous, active-high
//   bus            - rx_frame_buffer_if.slave: rx_mac_* input stream, out_* output stream
//   frame_drop     - one-cycle pulse per discarded frame
//   frames_pending - a committed frame has not been completely read out
//   drop_*_cnt     - saturating 16-bit drop counters (only with RX_FRAME_BUF_STATS_EN)
// Build option: define RX_FRAME_BUF_STATS_EN to add the drop counters.
// MIN_BYTES must be at least 2.
module rx_frame_buffer
  import eth_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned MIN_BYTES = MinBytesDefault
) (
  input  logic               rx_mac_clk,
  input  logic               reset,
  rx_frame_buffer_if.slave   bus,
  output logic               frame_drop,
  output logic               frames_pending
`ifdef RX_FRAME_BUF_STATS_EN
  ,
  output logic [15:0]        drop_err_cnt,
  output logic [15:0]        drop_runt_cnt,
  output logic [15:0]        drop_ovf_cnt
`endif
);

  localparam int unsigned     PtrW   = ADDR_W + 1;
  localparam int unsigned     CntW   = $clog2(MIN_BYTES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MIN_BYTES);

  // Write side
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] fill;
  logic            full;
  wr_state_e       wr_state_q, wr_state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  drop_reason_e    drop_q, drop_d;
  logic            wr_en;

  assign fill    = wr_ptr_q - rd_ptr_q;
  assign full    = fill[ADDR_W];
  assign cnt_inc = (cnt_q == CntMax) ? CntMax : cnt_q + CntW'(1);

  always_comb begin
    wr_en        = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_state_d   = wr_state_q;
    cnt_d        = cnt_q;
    drop_d       = DropNone;
    if (bus.rx_mac_valid) begin
      unique case (wr_state_q)
        WrIdle, WrRecv: begin
          if (full) begin
            wr_state_d = WrDrop;
            if (bus.rx_mac_last) drop_d = DropOvf;
          end else begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + PtrW'(1);
            cnt_d      = cnt_inc;
            wr_state_d = WrRecv;
            if (bus.rx_mac_last) begin
              if (bus.rx_mac_error) begin
                drop_d = DropErr;
              end else if (cnt_inc != CntMax) begin
                drop_d = DropRunt;
              end else begin
                commit_ptr_d = wr_ptr_q + PtrW'(1);
                wr_state_d   = WrIdle;
                cnt_d        = '0;
              end
            end
          end
        end
        WrDrop: begin
          if (bus.rx_mac_last) drop_d = DropOvf;
        end
        default: wr_state_d = WrIdle;
      endcase
      // Any drop rolls the write pointer back to the end of the last committed frame.
      if (drop_d != DropNone) begin
        wr_ptr_d   = commit_ptr_q;
        wr_state_d = WrIdle;
        cnt_d      = '0;
      end
    end
  end

  always_ff @(posedge rx_mac_clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      wr_state_q   <= WrIdle;
      cnt_q        <= '0;
      drop_q       <= DropNone;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      wr_state_q   <= wr_state_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
    end
  end

  assign frame_drop = (drop_q != DropNone);

  // Read side: RAM read register (ram_vld_q) feeds the output register. Comparing against the
  // next commit pointer lets the first byte be fetched on the committing edge itself.
  logic [EntryW-1:0] ram_q;
  logic              ram_vld_q;
  logic              avail, take, load, rd_en;
  rd_state_e         rd_state_q;
  logic              out_valid_q, out_last_q;
  logic [7:0]        out_data_q;

  assign avail = (rd_ptr_q != commit_ptr_d);
  assign take  = out_valid_q && bus.out_ready;
  assign load  = ram_vld_q && (!out_valid_q || bus.out_ready);
  assign rd_en = avail && (!ram_vld_q || load);

  always_ff @(posedge rx_mac_clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      ram_vld_q   <= 1'b0;
      rd_state_q  <= RdIdle;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (rd_en)     ram_vld_q <= 1'b1;
      else if (load) ram_vld_q <= 1'b0;
      if (load) begin
        out_valid_q <= 1'b1;
        out_last_q  <= ram_q[8];
        out_data_q  <= ram_q[7:0];
      end else if (take) begin
        out_valid_q <= 1'b0;
      end
      unique case (rd_state_q)
        RdIdle:   if (rd_en) rd_state_q <= RdFetch;
        RdFetch:  rd_state_q <= RdStream;
        RdStream: if (take && !load) rd_state_q <= rd_en ? RdFetch : RdIdle;
        default:  rd_state_q <= RdIdle;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;

  assign frames_pending = (rd_ptr_q != commit_ptr_q) || ram_vld_q || out_valid_q;

  rx_frame_ram #(
    .AddrW(ADDR_W)
  ) u_ram (
    .clk_i     (rx_mac_clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i ({bus.rx_mac_last, bus.rx_mac_data}),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (ram_q)
  );

`ifdef RX_FRAME_BUF_STATS_EN
  logic [15:0] err_cnt_q, runt_cnt_q, ovf_cnt_q;

  always_ff @(posedge rx_mac_clk) begin
    if (reset) begin
      err_cnt_q  <= '0;
      runt_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      unique case (drop_q)
        DropErr:  if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
        DropRunt: if (runt_cnt_q != '1) runt_cnt_q <= runt_cnt_q + 16'd1;
        DropOvf:  if (ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign drop_err_cnt  = err_cnt_q;
  assign drop_runt_cnt = runt_cnt_q;
  assign drop_ovf_cnt  = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed bench for rx_frame_buffer: a full-size instance and a 64-byte instance (overflow).
module tb_rx_frame_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       vld, lst, err, sel_s, rdy, rdy_s;
  logic [7:0] dat;

  int checks = 0;
  int errors = 0;

  rx_frame_buffer_if bus ();
  rx_frame_buffer_if bus_s ();

  assign bus.rx_mac_valid   = vld & ~sel_s;
  assign bus.rx_mac_data    = dat;
  assign bus.rx_mac_last    = lst;
  assign bus.rx_mac_error   = err;
  assign bus.out_ready      = rdy;
  assign bus_s.rx_mac_valid = vld & sel_s;
  assign bus_s.rx_mac_data  = dat;
  assign bus_s.rx_mac_last  = lst;
  assign bus_s.rx_mac_error = err;
  assign bus_s.out_ready    = rdy_s;

  logic frame_drop, frames_pending, frame_drop_s, frames_pending_s;
`ifdef RX_FRAME_BUF_STATS_EN
  logic [15:0] err_cnt, runt_cnt, ovf_cnt, err_cnt_s, runt_cnt_s, ovf_cnt_s;
`endif

  rx_frame_buffer #(
    .ADDR_W    (11),
    .MIN_BYTES (14)
  ) dut (
    .rx_mac_clk     (clk),
    .reset          (reset),
    .bus            (bus),
    .frame_drop     (frame_drop),
    .frames_pending (frames_pending)
`ifdef RX_FRAME_BUF_STATS_EN
    ,
    .drop_err_cnt   (err_cnt),
    .drop_runt_cnt  (runt_cnt),
    .drop_ovf_cnt   (ovf_cnt)
`endif
  );

  rx_frame_buffer #(
    .ADDR_W    (6),
    .MIN_BYTES (14)
  ) dut_s (
    .rx_mac_clk     (clk),
    .reset          (reset),
    .bus            (bus_s),
    .frame_drop     (frame_drop_s),
    .frames_pending (frames_pending_s)
`ifdef RX_FRAME_BUF_STATS_EN
    ,
    .drop_err_cnt   (err_cnt_s),
    .drop_runt_cnt  (runt_cnt_s),
    .drop_ovf_cnt   (ovf_cnt_s)
`endif
  );

  // Accepted output bytes {last, data}, sampled mid-cycle.
  logic [8:0] got[$];
  logic [8:0] got_s[$];

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) got.push_back({bus.out_last, bus.out_data});
    if (bus_s.out_valid && bus_s.out_ready) got_s.push_back({bus_s.out_last, bus_s.out_data});
  end

  // All tasks start and end 1 ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int len, input logic [7:0] base, input logic bad,
                            input logic term);
    for (int i = 0; i < len; i++) begin
      vld = 1'b1;
      dat = base + 8'(i);
      lst = term && (i == len - 1);
      err = bad && (i == len - 1);
      @(posedge clk);
      #1;
    end
    vld = 1'b0;
    lst = 1'b0;
    err = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int c = 0; c < 1000 && got.size() < n; c++) idle(1);
    idle(5);
  endtask

  task automatic test_reset;
    reset = 1'b1; vld = 1'b0; lst = 1'b0; err = 1'b0; dat = 8'h00;
    sel_s = 1'b0; rdy = 1'b1; rdy_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
    checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL reset_frame_drop got %b want 0", frame_drop); end
    checks++; if (frames_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", frames_pending); end
    checks++; if (bus_s.out_valid !== 1'b0) begin errors++; $display("FAIL reset_s_out_valid got %b want 0", bus_s.out_valid); end
    checks++; if (frames_pending_s !== 1'b0) begin errors++; $display("FAIL reset_s_pending got %b want 0", frames_pending_s); end
  endtask

  task automatic test_clean;
    logic [8:0] exp;
    got.delete();
    send_frame(64, 8'h00, 1'b0, 1'b1);
    checks++; if (frames_pending !== 1'b1) begin errors++; $display("FAIL clean_pending_n1 got %b want 1", frames_pending); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clean_valid_n1 got %b want 0", bus.out_valid); end
    checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL clean_drop got %b want 0", frame_drop); end
    idle(1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clean_valid_n2 got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL clean_first_data got %h want 00", bus.out_data); end
    wait_out(64);
    checks++; if (got.size() != 64) begin errors++; $display("FAIL clean_count got %0d want 64", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      exp = {i == 63, 8'(i)};
      checks++; if (got[i] !== exp) begin errors++; $display("FAIL clean_byte[%0d] got %h want %h", i, got[i], exp); end
    end
    checks++; if (frames_pending !== 1'b0) begin errors++; $display("FAIL clean_pending_end got %b want 0", frames_pending); end
  endtask

  task automatic test_error;
    logic [8:0] exp;
    got.delete();
    send_frame(64, 8'h40, 1'b1, 1'b1);
    checks++; if (frame_drop !== 1'b1) begin errors++; $display("FAIL err_drop_n1 got %b want 1", frame_drop); end
    checks++; if (frames_pending !== 1'b0) begin errors++; $display("FAIL err_pending got %b want 0", frames_pending); end
    idle(1);
    checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL err_drop_n2 got %b want 0", frame_drop); end
    idle(10);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL err_no_output got %0d want 0", got.size()); end
`ifdef RX_FRAME_BUF_STATS_EN
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL err_cnt got %0d want 1", err_cnt); end
`endif
    send_frame(64, 8'hA0, 1'b0, 1'b1);
    wait_out(64);
    checks++; if (got.size() != 64) begin errors++; $display("FAIL err_next_count got %0d want 64", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      exp = {i == 63, 8'hA0 + 8'(i)};
      checks++; if (got[i] !== exp) begin errors++; $display("FAIL err_next_byte[%0d] got %h want %h", i, got[i], exp); end
    end
  endtask

  task automatic test_runt;
    logic [8:0] exp;
    got.delete();
    send_frame(13, 8'h10, 1'b0, 1'b1);
    checks++; if (frame_drop !== 1'b1) begin errors++; $display("FAIL runt13_drop got %b want 1", frame_drop); end
    idle(10);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL runt13_no_output got %0d want 0", got.size()); end
`ifdef RX_FRAME_BUF_STATS_EN
    checks++; if (runt_cnt !== 16'd1) begin errors++; $display("FAIL runt_cnt got %0d want 1", runt_cnt); end
`endif
    send_frame(14, 8'h20, 1'b0, 1'b1);
    checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL runt14_drop got %b want 0", frame_drop); end
    wait_out(14);
    checks++; if (got.size() != 14) begin errors++; $display("FAIL runt14_count got %0d want 14", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      exp = {i == 13, 8'h20 + 8'(i)};
      checks++; if (got[i] !== exp) begin errors++; $display("FAIL runt14_byte[%0d] got %h want %h", i, got[i], exp); end
    end
  endtask

  task automatic test_overflow;
    logic [8:0] exp;
    got_s.delete();
    sel_s = 1'b1;
    rdy_s = 1'b0;
    send_frame(40, 8'h00, 1'b0, 1'b1);
    checks++; if (frame_drop_s !== 1'b0) begin errors++; $display("FAIL ovf_first_drop got %b want 0", frame_drop_s); end
    send_frame(40, 8'h80, 1'b0, 1'b1);
    checks++; if (frame_drop_s !== 1'b1) begin errors++; $display("FAIL ovf_second_drop got %b want 1", frame_drop_s); end
    checks++; if (frames_pending_s !== 1'b1) begin errors++; $display("FAIL ovf_pending got %b want 1", frames_pending_s); end
    sel_s = 1'b0;
    idle(3);
`ifdef RX_FRAME_BUF_STATS_EN
    checks++; if (ovf_cnt_s !== 16'd1) begin errors++; $display("FAIL ovf_cnt got %0d want 1", ovf_cnt_s); end
`endif
    rdy_s = 1'b1;
    for (int c = 0; c < 1000 && got_s.size() < 40; c++) idle(1);
    idle(10);
    checks++; if (got_s.size() != 40) begin errors++; $display("FAIL ovf_count got %0d want 40", got_s.size()); end
    for (int i = 0; i < got_s.size(); i++) begin
      exp = {i == 39, 8'(i)};
      checks++; if (got_s[i] !== exp) begin errors++; $display("FAIL ovf_byte[%0d] got %h want %h", i, got_s[i], exp); end
    end
    checks++; if (frames_pending_s !== 1'b0) begin errors++; $display("FAIL ovf_pending_end got %b want 0", frames_pending_s); end
  endtask

  task automatic test_backpressure;
    logic [8:0] exp;
    got.delete();
    rdy = 1'b0;
    fork
      send_frame(100, 8'h37, 1'b0, 1'b1);
      begin
        logic       pend;
        logic [8:0] hold;
        pend = 1'b0;
        hold = '0;
        for (int c = 0; c < 600 && got.size() < 100; c++) begin
          @(negedge clk);
          if (pend) begin
            checks++;
            if (bus.out_valid !== 1'b1 || {bus.out_last, bus.out_data} !== hold) begin
              errors++;
              $display("FAIL bp_hold got v=%b %h want v=1 %h", bus.out_valid,
                       {bus.out_last, bus.out_data}, hold);
            end
          end
          pend = bus.out_valid && !rdy;
          hold = {bus.out_last, bus.out_data};
          @(posedge clk);
          #1;
          rdy = ~rdy;
        end
      end
    join
    rdy = 1'b1;
    idle(5);
    checks++; if (got.size() != 100) begin errors++; $display("FAIL bp_count got %0d want 100", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      exp = {i == 99, 8'h37 + 8'(i)};
      checks++; if (got[i] !== exp) begin errors++; $display("FAIL bp_byte[%0d] got %h want %h", i, got[i], exp); end
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] exp;
    rdy = 1'b0;
    send_frame(20, 8'h55, 1'b0, 1'b1);
    send_frame(20, 8'h70, 1'b0, 1'b0);
    checks++; if (bus.out_data !== 8'h55) begin errors++; $display("FAIL rst_pre_data got %h want 55", bus.out_data); end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h want 00", bus.out_data); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", bus.out_last); end
    checks++; if (frames_pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b want 0", frames_pending); end
    checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %b want 0", frame_drop); end
`ifdef RX_FRAME_BUF_STATS_EN
    checks++; if ((err_cnt | runt_cnt | ovf_cnt) !== 16'd0) begin errors++; $display("FAIL rst_cnts got %h want 0000", err_cnt | runt_cnt | ovf_cnt); end
`endif
    got.delete();
    rdy = 1'b1;
    send_frame(64, 8'hC0, 1'b0, 1'b1);
    wait_out(64);
    checks++; if (got.size() != 64) begin errors++; $display("FAIL rst_next_count got %0d want 64", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      exp = {i == 63, 8'hC0 + 8'(i)};
      checks++; if (got[i] !== exp) begin errors++; $display("FAIL rst_next_byte[%0d] got %h want %h", i, got[i], exp); end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_error();
    test_runt();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_buffer.md
# rx_frame_buffer

Store-and-forward frame buffer directly downstream of the Triple-Speed Ethernet MAC receive interface. Accepts the MAC's byte stream (`rx_mac_valid/data/last/error`), writes each frame into a circular RAM and releases it to the bridge forwarding logic only once the whole frame has arrived clean. Errored, runt and overflowing frames are rolled back and never appear on the output. Runs entirely in the MAC receive clock domain.

## Interface
- `ADDR_W`, 11: RAM address width; depth = 2^ADDR_W bytes.
- `MIN_BYTES`, 14: minimum committed frame length; shorter frames are dropped as runts.
- `rx_mac_clk`  in  1: the only clock. Everything is sampled on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `rx_mac_valid`  in  1: input byte strobe. There is no backpressure.
- `rx_mac_data`  in  8: input byte.
- `rx_mac_last`  in  1: marks the final byte of a frame. Qualified by `rx_mac_valid`.
- `rx_mac_error`  in  1: frame bad. Sampled with the last byte.
- `out_valid`  out  1: output byte available.
- `out_data`  out  8: output byte.
- `out_last`  out  1: final byte of the output frame.
- `out_ready`  in  1: consumer accepts the byte when `out_valid && out_ready`.
- `frame_drop`  out  1: one-cycle pulse when a frame is discarded.
- `frames_pending`  out  1: at least one committed frame is not yet fully read.

## Operation
- Each RAM entry is 9 bits: {last, data}.
- Pointers `wr_ptr`, `commit_ptr` and `rd_ptr` are ADDR_W+1 bits, using the wrap bit for full/empty detection.
- Fill level = `wr_ptr - rd_ptr`. Full when fill = 2^ADDR_W.
- Write FSM:
  - WR_IDLE: the first valid byte goes to WR_RECV.
  - WR_RECV: each valid byte is written at `wr_ptr` and `wr_ptr` increments. A byte counter saturates at MIN_BYTES.
  - WR_DROP: entered when a valid byte arrives while full. Bytes are ignored until last.
- On a valid `rx_mac_last`:
  - The frame commits (`commit_ptr <= wr_ptr+1`, last byte written with its flag set) only if the FSM is in WR_RECV, the buffer is not full, `rx_mac_error`=0 and the byte count including the last byte is ≥ MIN_BYTES.
  - Otherwise `wr_ptr <= commit_ptr`, `frame_drop` pulses for one cycle, and the FSM returns to WR_IDLE.
- A one-byte frame (valid and last in the same cycle from WR_IDLE) follows the same rules, so it is dropped as a runt.
- Read FSM:
  - RD_IDLE: waits for `rd_ptr != commit_ptr`.
  - RD_FETCH: issues the RAM read.
  - RD_STREAM: output register loaded. Prefetches the next address so the output sustains 1 byte/cycle while `out_ready`=1.
  - After the accepted byte with `out_last`=1, goes to RD_IDLE, or directly continues when another frame is committed.
- `out_data` and `out_last` stay stable while `out_valid && !out_ready`. `out_valid` never drops without a handshake.
- Simultaneous write and read are allowed. Free space uses the registered `rd_ptr` and is therefore conservative by at most one cycle.
- Uncommitted bytes are never read: the read side compares against `commit_ptr` only.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `frame_drop`=0, `frames_pending`=0. All pointers are 0 and both FSMs are in IDLE.
- Reset mid-frame discards any partial or committed data.
- Commit happens on the edge that samples the last byte (cycle N). `frames_pending`=1 from N+1. `out_valid` rises at N+2 at the earliest.
- `frame_drop` is high in cycle N+1 only.
- The RAM has 1-cycle synchronous read latency, hidden by the prefetch during streaming.

## Configuration
- `RX_FRAME_BUF_STATS_EN` defined adds the output ports `drop_err_cnt`, `drop_runt_cnt` and `drop_ovf_cnt`, each 16 bits.
  - The counters saturate at 0xFFFF and clear on reset.
  - Each drop increments exactly one counter. Priority is overflow, then error, then runt.
- Without the macro, the ports and counters are absent. `frame_drop` behaviour is identical in both builds.

## Structure
- Shared package `eth_bridge_pkg`: write and read FSM state enums, drop-reason encoding and the MIN_BYTES default.
- Sub-module `rx_frame_ram`: simple dual-port RAM, ADDR_W × 9, registered read port, no reset on the array.

## Test plan
- **Clean frame:** 64 bytes 0x00..0x3F, last on 0x3F, error=0, out_ready=1 → `out_valid` at N+2, 64 consecutive bytes 0x00..0x3F, `out_last` only on 0x3F.
- **Errored frame:** 64-byte frame with `rx_mac_error`=1 on last → `frame_drop` pulse at N+1, no output. The next clean frame is output intact.
- **Runt:** 13-byte frame → dropped. A 14-byte frame → forwarded.
- **Overflow:** ADDR_W=6, out_ready=0, 40-byte frame then 40-byte frame → first committed, second dropped. Release `out_ready` → exactly 40 bytes out.
- **Backpressure:** toggle `out_ready` every cycle during a 100-byte frame → all 100 bytes in order, `out_data` held whenever not accepted.
- **Reset mid-frame:** assert `reset` after 20 bytes of a frame → all outputs 0 next cycle. A following 64-byte frame passes unchanged.
